// File: rtl/dcache_wbuf.sv
// Write buffer between the write-through data cache and the L2/bus port.
// Stores are posted to a FIFO and acked early; reads wait for the FIFO to drain.
module dcache_wbuf #(
  parameter int offset_width = 2,
  parameter int depth_width  = 2
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic [31:0]                        dcache_wbuf_addr,
  input  logic [31:0]                        dcache_wbuf_data,
  input  logic                               dcache_wbuf_req,
  input  logic                               dcache_wbuf_wr,
  input  logic                               dcache_wbuf_SUC,
  input  logic [1:0]                         dcache_wbuf_size,
  input  logic [3:0]                         dcache_wbuf_wstrb,
  output logic                               wbuf_dcache_addrOK,
  output logic                               wbuf_dcache_dataOK,
  output logic [32*(1<<offset_width)-1:0]    wbuf_dcache_line,
  output logic [31:0]                        wbuf_mem_addr,
  output logic [31:0]                        wbuf_mem_data,
  output logic                               wbuf_mem_req,
  output logic                               wbuf_mem_wr,
  output logic                               wbuf_mem_SUC,
  output logic [1:0]                         wbuf_mem_size,
  output logic [3:0]                         wbuf_mem_wstrb,
  input  logic                               mem_wbuf_addrOK,
  input  logic                               mem_wbuf_dataOK,
  input  logic [32*(1<<offset_width)-1:0]    mem_wbuf_line,
  output logic                               wbuf_empty
);

  localparam int LINE_W = 32 * (1 << offset_width);
  localparam int DEPTH  = 1 << depth_width;
  localparam logic [depth_width:0]   FULL_CNT = (depth_width + 1)'(DEPTH);
  localparam logic [depth_width:0]   CNT_ONE  = (depth_width + 1)'(1);
  localparam logic [depth_width-1:0] PTR_ONE  = depth_width'(1);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, RD_RESP} state_t;

  state_t                   state_q;
  logic [depth_width:0]     count_q;
  logic [depth_width-1:0]   wptr_q;
  logic [depth_width-1:0]   rptr_q;
  logic                     wr_ack_q;
  logic [LINE_W-1:0]        line_q;
  // Entry layout: {addr[70:39], data[38:7], wstrb[6:3], size[2:1], SUC[0]}
  logic [70:0]              fifo_q [DEPTH];
  logic [70:0]              head;

  logic push, pop, rd_pending, line_cap;

  assign head       = fifo_q[rptr_q];
  assign rd_pending = dcache_wbuf_req && !dcache_wbuf_wr;
  // Fullness is judged on the cycle-start count, so a same-cycle pop never frees a slot.
  assign push       = !rstn && dcache_wbuf_req && dcache_wbuf_wr && (count_q < FULL_CNT);
  assign pop        = (state_q == WR_WAIT && mem_wbuf_dataOK) ||
                      (state_q == WR_REQ && mem_wbuf_addrOK && mem_wbuf_dataOK);
  assign line_cap   = (state_q == RD_WAIT && mem_wbuf_dataOK) ||
                      (state_q == RD_REQ && mem_wbuf_addrOK && mem_wbuf_dataOK);

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q  <= IDLE;
      count_q  <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      wr_ack_q <= 1'b0;
      line_q   <= '0;
    end else begin
      wr_ack_q <= push;
      if (push) wptr_q <= wptr_q + PTR_ONE;
      if (pop)  rptr_q <= rptr_q + PTR_ONE;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
      if (line_cap) line_q <= mem_wbuf_line;
      case (state_q)
        IDLE: begin
          if (rd_pending && count_q == '0) state_q <= RD_REQ;
          else if (count_q != '0)          state_q <= WR_REQ;
        end
        WR_REQ:  if (mem_wbuf_addrOK) state_q <= mem_wbuf_dataOK ? IDLE : WR_WAIT;
        WR_WAIT: if (mem_wbuf_dataOK) state_q <= IDLE;
        RD_REQ:  if (mem_wbuf_addrOK) state_q <= mem_wbuf_dataOK ? RD_RESP : RD_WAIT;
        RD_WAIT: if (mem_wbuf_dataOK) state_q <= RD_RESP;
        RD_RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= {dcache_wbuf_addr, dcache_wbuf_data, dcache_wbuf_wstrb,
                                 dcache_wbuf_size, dcache_wbuf_SUC};
  end

  always_comb begin
    wbuf_mem_req   = 1'b0;
    wbuf_mem_wr    = 1'b0;
    wbuf_mem_addr  = '0;
    wbuf_mem_data  = '0;
    wbuf_mem_wstrb = '0;
    wbuf_mem_size  = '0;
    wbuf_mem_SUC   = 1'b0;
    if (state_q == WR_REQ) begin
      wbuf_mem_req   = 1'b1;
      wbuf_mem_wr    = 1'b1;
      wbuf_mem_addr  = head[70:39];
      wbuf_mem_data  = head[38:7];
      wbuf_mem_wstrb = head[6:3];
      wbuf_mem_size  = head[2:1];
      wbuf_mem_SUC   = head[0];
    end else if (state_q == RD_REQ) begin
      wbuf_mem_req   = 1'b1;
      wbuf_mem_addr  = dcache_wbuf_addr;
      wbuf_mem_size  = dcache_wbuf_size;
      wbuf_mem_SUC   = dcache_wbuf_SUC;
    end
  end

  assign wbuf_dcache_addrOK = push || (!rstn && state_q == RD_REQ && mem_wbuf_addrOK);
  assign wbuf_dcache_dataOK = wr_ack_q || (state_q == RD_RESP);
  assign wbuf_dcache_line   = line_q;
  assign wbuf_empty         = (count_q == '0) && (state_q != WR_REQ) && (state_q != WR_WAIT);

endmodule

// File: tb/tb_dcache_wbuf.sv
// Directed bench for dcache_wbuf: the bench plays both the cache and the memory side.
module tb_dcache_wbuf;
  logic         clk = 1'b0;
  logic         rstn;
  logic [31:0]  dcache_wbuf_addr, dcache_wbuf_data;
  logic         dcache_wbuf_req, dcache_wbuf_wr, dcache_wbuf_SUC;
  logic [1:0]   dcache_wbuf_size;
  logic [3:0]   dcache_wbuf_wstrb;
  logic         wbuf_dcache_addrOK, wbuf_dcache_dataOK;
  logic [127:0] wbuf_dcache_line;
  logic [31:0]  wbuf_mem_addr, wbuf_mem_data;
  logic         wbuf_mem_req, wbuf_mem_wr, wbuf_mem_SUC;
  logic [1:0]   wbuf_mem_size;
  logic [3:0]   wbuf_mem_wstrb;
  logic         mem_wbuf_addrOK, mem_wbuf_dataOK;
  logic [127:0] mem_wbuf_line;
  logic         wbuf_empty;

  int nchk = 0;
  int nerr = 0;

  dcache_wbuf #(.offset_width(2), .depth_width(2)) dut (
    .clk(clk), .rstn(rstn),
    .dcache_wbuf_addr(dcache_wbuf_addr), .dcache_wbuf_data(dcache_wbuf_data),
    .dcache_wbuf_req(dcache_wbuf_req), .dcache_wbuf_wr(dcache_wbuf_wr),
    .dcache_wbuf_SUC(dcache_wbuf_SUC), .dcache_wbuf_size(dcache_wbuf_size),
    .dcache_wbuf_wstrb(dcache_wbuf_wstrb),
    .wbuf_dcache_addrOK(wbuf_dcache_addrOK), .wbuf_dcache_dataOK(wbuf_dcache_dataOK),
    .wbuf_dcache_line(wbuf_dcache_line),
    .wbuf_mem_addr(wbuf_mem_addr), .wbuf_mem_data(wbuf_mem_data),
    .wbuf_mem_req(wbuf_mem_req), .wbuf_mem_wr(wbuf_mem_wr), .wbuf_mem_SUC(wbuf_mem_SUC),
    .wbuf_mem_size(wbuf_mem_size), .wbuf_mem_wstrb(wbuf_mem_wstrb),
    .mem_wbuf_addrOK(mem_wbuf_addrOK), .mem_wbuf_dataOK(mem_wbuf_dataOK),
    .mem_wbuf_line(mem_wbuf_line), .wbuf_empty(wbuf_empty)
  );

  always #5 clk = ~clk;

  // Advance to 3 time units after the next rising edge; inputs change here, outputs are sampled after #1.
  task automatic cyc();
    @(posedge clk);
    #3;
  endtask

  task automatic cache_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [1:0] sz, input logic suc);
    dcache_wbuf_req = 1'b1; dcache_wbuf_wr = 1'b1; dcache_wbuf_addr = a;
    dcache_wbuf_data = d; dcache_wbuf_wstrb = s; dcache_wbuf_size = sz; dcache_wbuf_SUC = suc;
  endtask

  task automatic cache_idle();
    dcache_wbuf_req = 1'b0; dcache_wbuf_wr = 1'b0; dcache_wbuf_addr = '0; dcache_wbuf_data = '0;
    dcache_wbuf_wstrb = '0; dcache_wbuf_size = '0; dcache_wbuf_SUC = 1'b0;
  endtask

  task automatic wait_mem_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (wbuf_mem_req) begin ok = 1'b1; break; end
      cyc();
    end
  endtask

  // Serves one downstream transaction: addrOK when req is seen, dataOK the following cycle.
  task automatic serve(output bit ok, output logic [71:0] ent);
    wait_mem_req(ok);
    ent = '0;
    if (ok) begin
      ent = {wbuf_mem_wr, wbuf_mem_addr, wbuf_mem_data, wbuf_mem_wstrb, wbuf_mem_size, wbuf_mem_SUC};
      mem_wbuf_addrOK = 1'b1;
      cyc();
      mem_wbuf_addrOK = 1'b0;
      mem_wbuf_dataOK = 1'b1;
      cyc();
      mem_wbuf_dataOK = 1'b0;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    cache_idle();
    mem_wbuf_addrOK = 1'b0; mem_wbuf_dataOK = 1'b0; mem_wbuf_line = '0;
    cyc(); cyc();
    #1;
    nchk++;
    if ({wbuf_dcache_addrOK, wbuf_dcache_dataOK, wbuf_mem_req, wbuf_empty} !== 4'b0001) begin
      nerr++; $display("FAIL reset_ctrl: got %b required 0001",
                       {wbuf_dcache_addrOK, wbuf_dcache_dataOK, wbuf_mem_req, wbuf_empty});
    end
    nchk++;
    if (wbuf_dcache_line !== 128'h0) begin
      nerr++; $display("FAIL reset_line: got %h required 0", wbuf_dcache_line);
    end
    rstn = 1'b0;
    cyc();
  endtask

  task automatic test_single_store();
    bit ok;
    cache_write(32'h1000, 32'hDEADBEEF, 4'b1111, 2'd2, 1'b0);
    #1;
    nchk++;
    if (wbuf_dcache_addrOK !== 1'b1) begin
      nerr++; $display("FAIL store_addrOK: got %b required 1", wbuf_dcache_addrOK);
    end
    cyc();
    cache_idle();
    #1;
    nchk++;
    if ({wbuf_dcache_dataOK, wbuf_dcache_addrOK, wbuf_empty} !== 3'b100) begin
      nerr++; $display("FAIL store_dataOK: got %b required 100",
                       {wbuf_dcache_dataOK, wbuf_dcache_addrOK, wbuf_empty});
    end
    wait_mem_req(ok);
    nchk++;
    if (!ok || {wbuf_mem_wr, wbuf_mem_addr, wbuf_mem_data, wbuf_mem_wstrb, wbuf_mem_size, wbuf_mem_SUC}
               !== {1'b1, 32'h1000, 32'hDEADBEEF, 4'b1111, 2'd2, 1'b0}) begin
      nerr++; $display("FAIL store_fwd: ok %0d got %h %h %b %0d %b", ok, wbuf_mem_addr,
                       wbuf_mem_data, wbuf_mem_wstrb, wbuf_mem_size, wbuf_mem_SUC);
    end
    cyc();
    mem_wbuf_addrOK = 1'b1;
    cyc();
    mem_wbuf_addrOK = 1'b0;
    #1;
    nchk++;
    if ({wbuf_mem_req, wbuf_empty} !== 2'b00) begin
      nerr++; $display("FAIL store_wait: got %b required 00", {wbuf_mem_req, wbuf_empty});
    end
    cyc();
    mem_wbuf_dataOK = 1'b1;
    cyc();
    mem_wbuf_dataOK = 1'b0;
    #1;
    nchk++;
    if ({wbuf_empty, wbuf_mem_req} !== 2'b10) begin
      nerr++; $display("FAIL store_empty: got %b required 10", {wbuf_empty, wbuf_mem_req});
    end
  endtask

  task automatic test_fill_full();
    bit ok;
    logic [71:0] ent;
    for (int k = 0; k < 4; k++) begin
      cache_write(32'h3000 + 32'(4 * k), 32'hA000_0000 + 32'(k), 4'b1111, 2'd2, 1'b0);
      #1;
      nchk++;
      if (wbuf_dcache_addrOK !== 1'b1) begin
        nerr++; $display("FAIL fill_accept%0d: got %b required 1", k, wbuf_dcache_addrOK);
      end
      cyc();
    end
    cache_write(32'h3010, 32'hA000_0004, 4'b1111, 2'd2, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      nchk++;
      if (wbuf_dcache_addrOK !== 1'b0) begin
        nerr++; $display("FAIL fill_full%0d: got %b required 0", k, wbuf_dcache_addrOK);
      end
      cyc();
    end
    wait_mem_req(ok);
    nchk++;
    if (!ok || wbuf_mem_addr !== 32'h3000) begin
      nerr++; $display("FAIL fill_order0: ok %0d got %h required 00003000", ok, wbuf_mem_addr);
    end
    mem_wbuf_addrOK = 1'b1;
    #1;
    nchk++;
    if (wbuf_dcache_addrOK !== 1'b0) begin
      nerr++; $display("FAIL fill_full_aok: got %b required 0", wbuf_dcache_addrOK);
    end
    cyc();
    mem_wbuf_addrOK = 1'b0; mem_wbuf_dataOK = 1'b1;
    #1;
    nchk++;
    if (wbuf_dcache_addrOK !== 1'b0) begin
      nerr++; $display("FAIL fill_pop_cycle: got %b required 0", wbuf_dcache_addrOK);
    end
    cyc();
    mem_wbuf_dataOK = 1'b0;
    #1;
    nchk++;
    if (wbuf_dcache_addrOK !== 1'b1) begin
      nerr++; $display("FAIL fill_after_pop: got %b required 1", wbuf_dcache_addrOK);
    end
    cyc();
    cache_idle();
    for (int k = 1; k < 5; k++) begin
      serve(ok, ent);
      nchk++;
      if (!ok || ent !== {1'b1, 32'h3000 + 32'(4 * k), 32'hA000_0000 + 32'(k), 4'b1111, 2'd2, 1'b0}) begin
        nerr++; $display("FAIL fill_order%0d: ok %0d got %h", k, ok, ent);
      end
    end
    #1;
    nchk++;
    if (wbuf_empty !== 1'b1) begin
      nerr++; $display("FAIL fill_empty: got %b required 1", wbuf_empty);
    end
  endtask

  task automatic test_read_after_writes();
    bit ok;
    logic [71:0] ent;
    logic [127:0] exp_line = 128'h0123456789ABCDEF_FEDCBA9876543210;
    cache_write(32'h2000, 32'h1111_1111, 4'b1111, 2'd2, 1'b0);
    cyc();
    cache_write(32'h2004, 32'h2222_2222, 4'b1111, 2'd2, 1'b0);
    cyc();
    cache_idle();
    dcache_wbuf_req = 1'b1; dcache_wbuf_wr = 1'b0; dcache_wbuf_addr = 32'h2000; dcache_wbuf_size = 2'd2;
    #1;
    nchk++;
    if (wbuf_dcache_addrOK !== 1'b0) begin
      nerr++; $display("FAIL rd_blocked: got %b required 0", wbuf_dcache_addrOK);
    end
    serve(ok, ent);
    nchk++;
    if (!ok || ent[71:39] !== {1'b1, 32'h2000}) begin
      nerr++; $display("FAIL rd_wr0: ok %0d got %h", ok, ent[71:39]);
    end
    serve(ok, ent);
    nchk++;
    if (!ok || ent[71:39] !== {1'b1, 32'h2004}) begin
      nerr++; $display("FAIL rd_wr1: ok %0d got %h", ok, ent[71:39]);
    end
    wait_mem_req(ok);
    #1;
    nchk++;
    if (!ok || {wbuf_mem_wr, wbuf_mem_addr, wbuf_mem_data, wbuf_mem_wstrb, wbuf_dcache_addrOK}
               !== {1'b0, 32'h2000, 32'h0, 4'b0000, 1'b0}) begin
      nerr++; $display("FAIL rd_issue: ok %0d got wr %b addr %h data %h wstrb %b aok %b", ok,
                       wbuf_mem_wr, wbuf_mem_addr, wbuf_mem_data, wbuf_mem_wstrb, wbuf_dcache_addrOK);
    end
    mem_wbuf_addrOK = 1'b1;
    #1;
    nchk++;
    if (wbuf_dcache_addrOK !== 1'b1) begin
      nerr++; $display("FAIL rd_addrOK: got %b required 1", wbuf_dcache_addrOK);
    end
    cyc();
    mem_wbuf_addrOK = 1'b0;
    cache_idle();
    cyc();
    mem_wbuf_dataOK = 1'b1; mem_wbuf_line = exp_line;
    #1;
    nchk++;
    if (wbuf_dcache_dataOK !== 1'b0) begin
      nerr++; $display("FAIL rd_early_dataOK: got %b required 0", wbuf_dcache_dataOK);
    end
    cyc();
    mem_wbuf_dataOK = 1'b0; mem_wbuf_line = '0;
    #1;
    nchk++;
    if (wbuf_dcache_dataOK !== 1'b1 || wbuf_dcache_line !== exp_line) begin
      nerr++; $display("FAIL rd_resp: got dataOK %b line %h required 1 %h",
                       wbuf_dcache_dataOK, wbuf_dcache_line, exp_line);
    end
    cyc();
    #1;
    nchk++;
    if (wbuf_dcache_dataOK !== 1'b0 || wbuf_dcache_line !== exp_line) begin
      nerr++; $display("FAIL rd_hold: got dataOK %b line %h", wbuf_dcache_dataOK, wbuf_dcache_line);
    end
  endtask

  task automatic test_suc_byte();
    bit ok;
    logic [71:0] ent;
    cache_write(32'h1FE00003, 32'h0000_00A5, 4'b1000, 2'd0, 1'b1);
    cyc();
    cache_idle();
    serve(ok, ent);
    nchk++;
    if (!ok || ent !== {1'b1, 32'h1FE00003, 32'h0000_00A5, 4'b1000, 2'd0, 1'b1}) begin
      nerr++; $display("FAIL suc_fwd: ok %0d got %h", ok, ent);
    end
  endtask

  task automatic test_push_pop();
    bit ok;
    logic [71:0] ent;
    cache_write(32'h4000, 32'h0000_0040, 4'b0011, 2'd1, 1'b0);
    cyc();
    cache_idle();
    wait_mem_req(ok);
    mem_wbuf_addrOK = 1'b1;
    cyc();
    mem_wbuf_addrOK = 1'b0; mem_wbuf_dataOK = 1'b1;
    cache_write(32'h4004, 32'h0000_0044, 4'b1100, 2'd1, 1'b0);
    #1;
    nchk++;
    if (!ok || wbuf_dcache_addrOK !== 1'b1) begin
      nerr++; $display("FAIL pp_accept: ok %0d got %b required 1", ok, wbuf_dcache_addrOK);
    end
    cyc();
    mem_wbuf_dataOK = 1'b0;
    cache_idle();
    serve(ok, ent);
    nchk++;
    if (!ok || ent !== {1'b1, 32'h4004, 32'h0000_0044, 4'b1100, 2'd1, 1'b0}) begin
      nerr++; $display("FAIL pp_second: ok %0d got %h", ok, ent);
    end
    cyc();
    #1;
    nchk++;
    if ({wbuf_empty, wbuf_mem_req} !== 2'b10) begin
      nerr++; $display("FAIL pp_empty: got %b required 10", {wbuf_empty, wbuf_mem_req});
    end
  endtask

  task automatic test_same_cycle_read();
    bit ok;
    int na, nd, first_d;
    logic [127:0] exp_line = 128'hCAFE0000_11112222_33334444_55556666;
    logic [127:0] got_line = '0;
    dcache_wbuf_req = 1'b1; dcache_wbuf_wr = 1'b0; dcache_wbuf_addr = 32'h1FE00010;
    dcache_wbuf_size = 2'd2; dcache_wbuf_SUC = 1'b1;
    wait_mem_req(ok);
    nchk++;
    if (!ok || {wbuf_mem_wr, wbuf_mem_SUC, wbuf_mem_addr} !== {1'b0, 1'b1, 32'h1FE00010}) begin
      nerr++; $display("FAIL sc_issue: ok %0d got wr %b SUC %b addr %h", ok,
                       wbuf_mem_wr, wbuf_mem_SUC, wbuf_mem_addr);
    end
    mem_wbuf_addrOK = 1'b1; mem_wbuf_dataOK = 1'b1; mem_wbuf_line = exp_line;
    #1;
    na = int'(wbuf_dcache_addrOK);
    nd = int'(wbuf_dcache_dataOK);
    first_d = -1;
    cyc();
    mem_wbuf_addrOK = 1'b0; mem_wbuf_dataOK = 1'b0; mem_wbuf_line = '0;
    cache_idle();
    for (int i = 0; i < 4; i++) begin
      #1;
      na += int'(wbuf_dcache_addrOK);
      if (wbuf_dcache_dataOK) begin
        nd++;
        if (first_d < 0) begin first_d = i; got_line = wbuf_dcache_line; end
      end
      cyc();
    end
    nchk++;
    if (na != 1 || nd != 1 || first_d != 0) begin
      nerr++; $display("FAIL sc_pulses: got addrOK %0d dataOK %0d at %0d required 1 1 0", na, nd, first_d);
    end
    nchk++;
    if (got_line !== exp_line) begin
      nerr++; $display("FAIL sc_line: got %h required %h", got_line, exp_line);
    end
  endtask

  task automatic test_reset_mid_drain();
    bit ok;
    int nreq;
    for (int k = 0; k < 3; k++) begin
      cache_write(32'h5000 + 32'(4 * k), 32'(k), 4'b1111, 2'd2, 1'b0);
      cyc();
    end
    cache_idle();
    wait_mem_req(ok);
    mem_wbuf_addrOK = 1'b1;
    cyc();
    mem_wbuf_addrOK = 1'b0;
    rstn = 1'b1;
    cyc();
    rstn = 1'b0;
    #1;
    nchk++;
    if (!ok || {wbuf_mem_req, wbuf_empty, wbuf_dcache_dataOK} !== 3'b010) begin
      nerr++; $display("FAIL rst_drain: ok %0d got %b required 010", ok,
                       {wbuf_mem_req, wbuf_empty, wbuf_dcache_dataOK});
    end
    nreq = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      #1;
      nreq += int'(wbuf_mem_req) + int'(wbuf_dcache_dataOK);
    end
    nchk++;
    if (nreq != 0) begin
      nerr++; $display("FAIL rst_quiet: got %0d activity cycles required 0", nreq);
    end
  endtask

  initial begin
    test_reset();
    test_single_store();
    test_fill_full();
    test_read_after_writes();
    test_suc_byte();
    test_push_pop();
    test_same_cycle_read();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
